// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate byte cache: 8 lines x 4 bytes,
// with a four-state miss FSM talking to a 32-bit-block data memory.
module dcache_ctrl #(
    parameter int LINES = 8,
    parameter int TAG_W = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        read,
    input  logic        write,
    input  logic [7:0]  address,
    input  logic [7:0]  writedata,
    output logic [7:0]  readdata,
    output logic        busywait,
    output logic        mem_read,
    output logic        mem_write,
    output logic [5:0]  mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITEBACK = 2'd1;
    localparam logic [1:0] FETCH     = 2'd2;
    localparam logic [1:0] UPDATE    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [TAG_W-1:0] req_tag;
    logic [2:0]       idx;
    logic [1:0]       off;
    logic             hit;
    logic             req;
    logic             wr_hit;

    assign req_tag = address[7:5];
    assign idx     = address[4:2];
    assign off     = address[1:0];
    assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
    assign req     = read || write;
    // write wins when both strobes are high
    assign wr_hit  = (state_q == IDLE) && write && hit;

    // gated by hit so the port reads zero while nothing is cached
    assign readdata = hit ? data_q[idx][{off, 3'b000} +: 8] : 8'h00;

    always_comb begin
        state_d       = state_q;
        busywait      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = address[7:2];
        mem_writedata = 32'h0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    busywait = 1'b1;
                    state_d  = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                busywait      = 1'b1;
                mem_write     = 1'b1;
                mem_address   = {tag_q[idx], idx};
                mem_writedata = data_q[idx];
                if (!mem_busywait) state_d = FETCH;
            end
            FETCH: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) state_d = UPDATE;
            end
            default: begin
                busywait = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == UPDATE) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else if (wr_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    // payload arrays carry no reset; valid bits guard them
    always_ff @(posedge CLK) begin
        if (state_q == UPDATE) begin
            tag_q[idx]  <= req_tag;
            data_q[idx] <= mem_readdata;
        end else if (wr_hit && !RESET) begin
            data_q[idx][{off, 3'b000} +: 8] <= writedata;
        end
    end

endmodule
